// File: rtl/vga_scanout.sv
// VGA scanout: timing counters, frame-buffer read addressing and a two-stage
// pipeline that keeps the returned pixel data aligned with the sync pulses.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [ADDR_W-1:0]  fb_endereco,
  output logic               fb_read_enable,
  input  logic [COLOR_W-1:0] fb_data,
  output logic               fb_livre,
  output logic [2:0]         vga_r,
  output logic [2:0]         vga_g,
  output logic [2:0]         vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr;
  logic              active;
  logic              h_last;
  logic              v_last;
  logic              wrap;
  logic              hs_now;
  logic              vs_now;
  logic              active_d;
  logic              hs_d;
  logic              vs_d;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));
  assign wrap   = h_last && v_last;
  assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_now = !((h_cnt >= HW'(HS_FIRST)) && (h_cnt <= HW'(HS_LAST)));
  assign vs_now = !((v_cnt >= VW'(VS_FIRST)) && (v_cnt <= VW'(VS_LAST)));

  // The port is only ours while a visible pixel is being fetched; reset frees it.
  assign fb_read_enable = pix_en && active && rst_n;
  assign fb_livre       = !(active && rst_n);
  assign fb_endereco    = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      addr  <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (wrap) begin
        addr <= '0;
      end else if (active) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
    end else if (pix_en) begin
      active_d <= active;
      hs_d     <= hs_now;
      vs_d     <= vs_now;
    end
  end

  // Data for the pixel read on the previous pix_en edge is on fb_data now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else if (pix_en) begin
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
      if (active_d) begin
        vga_r <= fb_data[8:6];
        vga_g <= fb_data[5:3];
        vga_b <= fb_data[2:0];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && wrap;
    end
  end

endmodule
